subword_access_sequencer: RTL and testbench

// - Front-end controller for the 32-bit RAM built from four 8-bit byte-lane sub-RAMs.
// - Accepts byte-addressed load/store requests of byte, half or word size.
// - Rotates store data and byte enables into lane position and drives the sub-RAM port.
// - Rotates and merges load data back to bit 0.
// - Splits word-boundary-crossing accesses into two sequenced RAM accesses.

---
 rtl/subword_access_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_subword_access_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subword_access_sequencer.sv
// rtl/subword_access_sequencer.sv - byte/half/word access sequencer over four byte-lane sub-RAMs
// Optional macro MISALIGN_SPLIT_EN: word-crossing accesses are split into two RAM accesses.
module subword_access_sequencer #(
   parameter int ADDR_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam logic [ADDR_W-3:0] WORD_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT, S_RESP} state_t;
   state_t state_q, state_d;

   logic              accept;
   logic [3:0]        req_mask;
   logic [7:0]        req_be8;
   logic              req_cross, req_illegal, req_reject;
   logic [31:0]       req_wrot;

   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-3:0] w0_q, w0_d;
   logic [31:0]       wrot_q, wrot_d;
   logic [3:0]        be_lo_q, be_lo_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
`ifdef MISALIGN_SPLIT_EN
   logic              cross_q, cross_d;
   logic [3:0]        be_hi_q, be_hi_d;
   logic [31:0]       word0_q, word0_d;
`endif

   logic [63:0]       load_pair;
   logic [31:0]       lane_mask, load_merged;

   assign accept = req_valid && req_ready;

   // Request decode: lane mask, 8-bit split enable pattern, rotated store data
   always_comb begin
      case (req_size)
         2'b01:   req_mask = 4'b0011;
         2'b10:   req_mask = 4'b1111;
         default: req_mask = 4'b0001;
      endcase
      req_be8     = {4'b0000, req_mask} << req_addr[1:0];
      req_cross   = |req_be8[7:4];
      req_illegal = (req_size == 2'b11);
`ifdef MISALIGN_SPLIT_EN
      req_reject  = req_illegal;
`else
      req_reject  = req_illegal || req_cross;
`endif
      case (req_addr[1:0])
         2'd1:    req_wrot = {req_wdata[23:0], req_wdata[31:24]};
         2'd2:    req_wrot = {req_wdata[15:0], req_wdata[31:16]};
         2'd3:    req_wrot = {req_wdata[7:0],  req_wdata[31:8]};
         default: req_wrot = req_wdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = req_reject ? S_RESP : S_ISSUE0;
`ifdef MISALIGN_SPLIT_EN
         S_ISSUE0: state_d = cross_q ? S_ISSUE1 : S_WAIT;
         S_ISSUE1: state_d = S_WAIT;
`else
         S_ISSUE0: state_d = S_WAIT;
`endif
         S_WAIT:   state_d = S_RESP;
         S_RESP:   if (resp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Load merge: window of the (optional) two-word pair starting at the byte offset
   always_comb begin
      load_pair = {32'b0, mem_rdata};
`ifdef MISALIGN_SPLIT_EN
      if (cross_q) load_pair = {mem_rdata, word0_q};
`endif
      case (size_q)
         2'b00:   lane_mask = 32'h0000_00FF;
         2'b01:   lane_mask = 32'h0000_FFFF;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
      load_merged = 32'(load_pair >> {off_q, 3'b000}) & lane_mask;
   end

   always_comb begin
      we_d    = we_q;
      size_d  = size_q;
      off_d   = off_q;
      w0_d    = w0_q;
      wrot_d  = wrot_q;
      be_lo_d = be_lo_q;
      err_d   = err_q;
      rdata_d = rdata_q;
`ifdef MISALIGN_SPLIT_EN
      cross_d = cross_q;
      be_hi_d = be_hi_q;
      word0_d = word0_q;
`endif
      if (accept) begin
         we_d    = req_we;
         size_d  = req_size;
         off_d   = req_addr[1:0];
         w0_d    = req_addr[ADDR_W-1:2];
         wrot_d  = req_wrot;
         be_lo_d = req_be8[3:0];
         err_d   = req_reject;
         rdata_d = '0;
`ifdef MISALIGN_SPLIT_EN
         cross_d = req_cross;
         be_hi_d = req_be8[7:4];
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      if (state_q == S_ISSUE1) word0_d = mem_rdata;
`endif
      if (state_q == S_WAIT) rdata_d = we_q ? 32'b0 : load_merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         w0_q    <= '0;
         wrot_q  <= '0;
         be_lo_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
         cross_q <= 1'b0;
         be_hi_q <= '0;
         word0_q <= '0;
`endif
      end else begin
         we_q    <= we_d;
         size_q  <= size_d;
         off_q   <= off_d;
         w0_q    <= w0_d;
         wrot_q  <= wrot_d;
         be_lo_q <= be_lo_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
`ifdef MISALIGN_SPLIT_EN
         cross_q <= cross_d;
         be_hi_q <= be_hi_d;
         word0_q <= word0_d;
`endif
      end
   end

   // req_ready is gated by rst so it reads 0 while reset is held
   always_comb begin
      req_ready  = (state_q == S_IDLE) && !rst;
      resp_valid = (state_q == S_RESP);
      resp_rdata = resp_valid ? rdata_q : 32'b0;
      resp_err   = resp_valid && err_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = 4'b0000;
      mem_wdata  = 32'b0;
      case (state_q)
         S_ISSUE0: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = w0_q;
            mem_be    = be_lo_q;
            mem_wdata = wrot_q;
         end
`ifdef MISALIGN_SPLIT_EN
         S_ISSUE1: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = w0_q + WORD_ONE;
            mem_be    = be_hi_q;
            mem_wdata = wrot_q;
         end
`endif
         default: ;
      endcase
   end
endmodule

// File: tb/tb_subword_access_sequencer.sv
// tb/tb_subword_access_sequencer.sv - directed-vector bench for subword_access_sequencer
// Expectations follow MISALIGN_SPLIT_EN the same way the design build does.
module tb_subword_access_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [17:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] ram [0:65535];
   logic [15:0] log_addr  [0:63];
   logic [3:0]  log_be    [0:63];
   logic [31:0] log_wdata [0:63];
   logic        log_we    [0:63];
   int          log_n = 0;

   subword_access_sequencer #(.ADDR_W(18)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Byte-lane RAM, read data one cycle after mem_en
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= ram[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en) begin
         if (log_n < 64) begin
            log_addr[log_n]  <= mem_addr;
            log_be[log_n]    <= mem_be;
            log_wdata[log_n] <= mem_wdata;
            log_we[log_n]    <= mem_we;
         end
         log_n <= log_n + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_req(input logic we, input logic [1:0] size, input logic [17:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic held, output logic rv_after, output logic rdy_after,
                         output int base);
      int n;
      @(negedge clk);
      base = log_n;
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      resp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
      rdata = resp_rdata; err = resp_err; held = resp_valid;
      for (int i = 0; i < hold; i++) begin @(negedge clk); held &= resp_valid; end
      resp_ready = 1'b1;
      @(negedge clk);
      rv_after = resp_valid; rdy_after = req_ready;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b exp 0", mem_en); end
      n_vec++; if (mem_be !== 4'h0) begin n_err++; $display("FAIL rst_mem_be: got %h exp 0", mem_be); end
      n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
   endtask

   task automatic test_word();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b1, 2'b10, 18'h10, 32'hAABBCCDD, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL word_st_latency: got %0d exp 3", lat); end
      n_vec++; if (log_n - b !== 1) begin n_err++; $display("FAIL word_st_count: got %0d exp 1", log_n - b); end
      n_vec++; if (log_addr[b] !== 16'h4) begin n_err++; $display("FAIL word_st_addr: got %h exp 4", log_addr[b]); end
      n_vec++; if (log_be[b] !== 4'hF) begin n_err++; $display("FAIL word_st_be: got %h exp f", log_be[b]); end
      n_vec++; if (log_wdata[b] !== 32'hAABBCCDD) begin n_err++; $display("FAIL word_st_wdata: got %h exp aabbccdd", log_wdata[b]); end
      n_vec++; if (log_we[b] !== 1'b1) begin n_err++; $display("FAIL word_st_we: got %b exp 1", log_we[b]); end
      n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL word_st_resp: got %h/%b exp 0/0", rd, er); end
      n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL word_st_pulse: got %b exp 0", ra); end
      n_vec++; if (ry !== 1'b1) begin n_err++; $display("FAIL word_st_ready_after: got %b exp 1", ry); end
      do_req(1'b0, 2'b10, 18'h10, 32'h0, 2, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL word_ld_latency: got %0d exp 3", lat); end
      n_vec++; if (rd !== 32'hAABBCCDD) begin n_err++; $display("FAIL word_ld_rdata: got %h exp aabbccdd", rd); end
      n_vec++; if (hd !== 1'b1) begin n_err++; $display("FAIL word_ld_hold: got %b exp 1", hd); end
      n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL word_ld_release: got %b exp 0", ra); end
      n_vec++; if (log_n - b !== 1 || log_we[b] !== 1'b0) begin n_err++; $display("FAIL word_ld_access: got %0d/%b exp 1/0", log_n - b, log_we[b]); end
   endtask

   task automatic test_byte();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b1, 2'b00, 18'h13, 32'h0000005A, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (log_addr[b] !== 16'h4) begin n_err++; $display("FAIL byte_st_addr: got %h exp 4", log_addr[b]); end
      n_vec++; if (log_be[b] !== 4'h8) begin n_err++; $display("FAIL byte_st_be: got %h exp 8", log_be[b]); end
      n_vec++; if (log_wdata[b] !== 32'h5A000000) begin n_err++; $display("FAIL byte_st_wdata: got %h exp 5a000000", log_wdata[b]); end
      do_req(1'b0, 2'b00, 18'h13, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h0000005A) begin n_err++; $display("FAIL byte_ld_rdata: got %h exp 0000005a", rd); end
      do_req(1'b0, 2'b10, 18'h10, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h5ABBCCDD) begin n_err++; $display("FAIL byte_other_lanes: got %h exp 5abbccdd", rd); end
   endtask

   task automatic test_half();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b1, 2'b01, 18'h22, 32'h1234CAFE, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (log_addr[b] !== 16'h8 || log_be[b] !== 4'hC) begin n_err++; $display("FAIL half_st_addr_be: got %h/%h exp 8/c", log_addr[b], log_be[b]); end
      n_vec++; if (log_wdata[b] !== 32'hCAFE1234) begin n_err++; $display("FAIL half_st_wdata: got %h exp cafe1234", log_wdata[b]); end
      do_req(1'b0, 2'b01, 18'h22, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h0000CAFE) begin n_err++; $display("FAIL half_ld_rdata: got %h exp 0000cafe", rd); end
      do_req(1'b0, 2'b01, 18'h11, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h0000BBCC) begin n_err++; $display("FAIL half_ld_off1: got %h exp 0000bbcc", rd); end
   endtask

   task automatic test_split();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b1, 2'b10, 18'h0E, 32'h11223344, 0, lat, rd, er, hd, ra, ry, b);
`ifdef MISALIGN_SPLIT_EN
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL split_st_latency: got %0d exp 4", lat); end
      n_vec++; if (log_n - b !== 2) begin n_err++; $display("FAIL split_st_count: got %0d exp 2", log_n - b); end
      n_vec++; if (log_addr[b] !== 16'h3 || log_be[b] !== 4'hC) begin n_err++; $display("FAIL split_st_first: got %h/%h exp 3/c", log_addr[b], log_be[b]); end
      n_vec++; if (log_wdata[b] !== 32'h33441122) begin n_err++; $display("FAIL split_st_wdata0: got %h exp 33441122", log_wdata[b]); end
      n_vec++; if (log_addr[b+1] !== 16'h4 || log_be[b+1] !== 4'h3) begin n_err++; $display("FAIL split_st_second: got %h/%h exp 4/3", log_addr[b+1], log_be[b+1]); end
      n_vec++; if (log_wdata[b+1] !== 32'h33441122) begin n_err++; $display("FAIL split_st_wdata1: got %h exp 33441122", log_wdata[b+1]); end
      do_req(1'b0, 2'b10, 18'h0E, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL split_ld_latency: got %0d exp 4", lat); end
      n_vec++; if (rd !== 32'h11223344 || er !== 1'b0) begin n_err++; $display("FAIL split_ld_rdata: got %h/%b exp 11223344/0", rd, er); end
      do_req(1'b0, 2'b10, 18'h10, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h5ABB1122) begin n_err++; $display("FAIL split_word4: got %h exp 5abb1122", rd); end
`else
      n_vec++; if (log_n - b !== 0) begin n_err++; $display("FAIL nosplit_st_count: got %0d exp 0", log_n - b); end
      n_vec++; if (er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL nosplit_st_resp: got %b/%h exp 1/0", er, rd); end
      do_req(1'b0, 2'b10, 18'h0E, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (er !== 1'b1 || rd !== 32'h0 || log_n - b !== 0) begin n_err++; $display("FAIL nosplit_ld: got %b/%h/%0d exp 1/0/0", er, rd, log_n - b); end
      do_req(1'b0, 2'b10, 18'h10, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h5ABBCCDD) begin n_err++; $display("FAIL nosplit_word4: got %h exp 5abbccdd", rd); end
`endif
   endtask

   task automatic test_illegal();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b0, 2'b11, 18'h10, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %b exp 1", er); end
      n_vec++; if (rd !== 32'h0 || log_n - b !== 0) begin n_err++; $display("FAIL illegal_quiet: got %h/%0d exp 0/0", rd, log_n - b); end
   endtask

   task automatic test_wrap();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry;
      do_req(1'b1, 2'b01, 18'h3FFFF, 32'h0000BEEF, 0, lat, rd, er, hd, ra, ry, b);
`ifdef MISALIGN_SPLIT_EN
      n_vec++; if (log_addr[b] !== 16'hFFFF || log_be[b] !== 4'h8) begin n_err++; $display("FAIL wrap_first: got %h/%h exp ffff/8", log_addr[b], log_be[b]); end
      n_vec++; if (log_wdata[b] !== 32'hEF0000BE) begin n_err++; $display("FAIL wrap_wdata: got %h exp ef0000be", log_wdata[b]); end
      n_vec++; if (log_addr[b+1] !== 16'h0000 || log_be[b+1] !== 4'h1) begin n_err++; $display("FAIL wrap_second: got %h/%h exp 0000/1", log_addr[b+1], log_be[b+1]); end
      do_req(1'b0, 2'b01, 18'h3FFFF, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
      n_vec++; if (rd !== 32'h0000BEEF || lat !== 4) begin n_err++; $display("FAIL wrap_ld: got %h/%0d exp 0000beef/4", rd, lat); end
`else
      n_vec++; if (er !== 1'b1 || log_n - b !== 0) begin n_err++; $display("FAIL wrap_nosplit: got %b/%0d exp 1/0", er, log_n - b); end
`endif
   endtask

   task automatic test_reset_mid();
      int lat, b; logic [31:0] rd; logic er, hd, ra, ry, seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
`ifdef MISALIGN_SPLIT_EN
      req_addr = 18'h0E;
`else
      req_addr = 18'h10;
`endif
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
`ifdef MISALIGN_SPLIT_EN
      @(negedge clk);
`endif
      n_vec++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rmid_in_issue: got %b exp 1", mem_en); end
      rst = 1'b1; #1;
      n_vec++; if (mem_en !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL rmid_reset: got en %b rdy %b exp 0/0", mem_en, req_ready); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); seen |= resp_valid; end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_no_resp: got %b exp 0", seen); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got %b exp 1", req_ready); end
      do_req(1'b0, 2'b10, 18'h10, 32'h0, 0, lat, rd, er, hd, ra, ry, b);
`ifdef MISALIGN_SPLIT_EN
      n_vec++; if (rd !== 32'h5ABB1122 || lat !== 3) begin n_err++; $display("FAIL rmid_after: got %h/%0d exp 5abb1122/3", rd, lat); end
`else
      n_vec++; if (rd !== 32'h5ABBCCDD || lat !== 3) begin n_err++; $display("FAIL rmid_after: got %h/%0d exp 5abbccdd/3", rd, lat); end
`endif
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_split();
      test_illegal();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
